// File: rtl/home_inventory_pkg.sv
// Shared definitions for the ADC frame FIFO: writer-state encoding,
// frame length derivation and the bit positions of the sticky status flags.
package home_inventory_pkg;

   // Writer FSM states: waiting for a frame, storing one, or discarding one
   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_FILL = 2'd1,
      WR_DROP = 2'd2
   } wr_state_e;

   // Bit positions of the sticky status flags inside the flag register
   localparam int FLAG_OVERRUN_BIT   = 0;
   localparam int FLAG_FRAME_ERR_BIT = 1;
   localparam int FLAG_W             = 2;

   // A frame is one status word followed by one word per channel
   function automatic int frameWords(input int numCh);
      return numCh + 1;
   endfunction

endpackage

// File: rtl/hi_fifo_ram.sv
// Storage array for the ADC frame FIFO: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module hi_fifo_ram #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 32,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write the incoming word on the rising edge when enabled
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/adc_frame_fifo.sv
// ADC frame FIFO: stores whole frames (status word + NUM_CH samples) and
// makes them visible to the reader only once the last word has arrived.
// Frames that do not fit are dropped and counted; malformed frames are flagged.
// Optional macro HOME_INV_ADC_FIFO_WM_EN adds a level watermark to irq_o.
module adc_frame_fifo
   import home_inventory_pkg::*;
#(
   parameter  int DATA_W  = 32,
   parameter  int DEPTH   = 32,
   parameter  int NUM_CH  = 8,
   localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_ni,
   input  logic               flush_i,
   input  logic               in_valid_i,
   input  logic               in_sof_i,
   input  logic [DATA_W-1:0]  in_data_i,
   input  logic               pop_i,
   output logic [DATA_W-1:0]  rd_data_o,
   output logic [LEVEL_W-1:0] level_o,
   input  logic               clr_flags_i,
   output logic               overrun_o,
   output logic               frame_err_o,
   output logic [15:0]        drop_count_o,
   input  logic [LEVEL_W-1:0] wm_i,
   output logic               irq_o
);

   localparam int FRAME_W = frameWords(NUM_CH);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int BEAT_W  = 5;

   localparam logic [LEVEL_W-1:0] C_DEPTH     = LEVEL_W'(DEPTH);
   localparam logic [LEVEL_W-1:0] C_FRAME     = LEVEL_W'(FRAME_W);
   localparam logic [BEAT_W-1:0]  C_LAST_BEAT = BEAT_W'(FRAME_W - 1);

   wr_state_e          r_state;
   logic [BEAT_W-1:0]  r_beat;
   logic [PTR_W-1:0]   r_wrPtr;
   logic [PTR_W-1:0]   r_shadowPtr;
   logic [PTR_W-1:0]   r_rdPtr;
   logic [LEVEL_W-1:0] r_level;
   logic [FLAG_W-1:0]  r_flags;
   logic [15:0]        r_dropCnt;
   logic               r_irq;

   logic               w_sofBeat;
   logic               w_dataBeat;
   logic               w_spaceOk;
   logic               w_fillWr;
   logic               w_commit;
   logic               w_popOk;
   logic               w_we;
   logic [PTR_W-1:0]   w_waddr;
   logic               w_setOvr;
   logic               w_setErr;
   logic               w_wmHit;
   logic [DATA_W-1:0]  w_ramData;

   assign w_sofBeat  = in_valid_i & in_sof_i;
   assign w_dataBeat = in_valid_i & ~in_sof_i;
   assign w_spaceOk  = (C_DEPTH - r_level) >= C_FRAME;
   assign w_fillWr   = w_dataBeat & (r_state == WR_FILL);
   assign w_commit   = w_fillWr & (r_beat == C_LAST_BEAT);
   assign w_popOk    = pop_i & (r_level != '0);
   assign w_we       = ~flush_i & ((w_sofBeat & w_spaceOk) | w_fillWr);
   assign w_waddr    = w_sofBeat ? r_wrPtr : r_shadowPtr;
   assign w_setOvr   = ~flush_i & w_sofBeat & ~w_spaceOk;
   assign w_setErr   = ~flush_i & ((w_sofBeat & (r_state != WR_IDLE)) |
                                   (w_dataBeat & (r_state == WR_IDLE)));

`ifdef HOME_INV_ADC_FIFO_WM_EN
   assign w_wmHit = (wm_i != '0) && (r_level >= wm_i);
`else
   // The watermark is disabled; wm_i is referenced only to keep the port live
   assign w_wmHit = 1'b0 && (wm_i != '0);
`endif

   hi_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .i_clk   (wb_clk_i),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (in_data_i),
      .i_raddr (r_rdPtr),
      .o_rdata (w_ramData)
   );

   // Writer FSM plus pointer and level bookkeeping; a new SOF always restarts
   // admission from the committed pointer, which also rewinds a partial frame
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state     <= WR_IDLE;
         r_beat      <= '0;
         r_wrPtr     <= '0;
         r_shadowPtr <= '0;
         r_rdPtr     <= '0;
         r_level     <= '0;
      end else if (flush_i) begin
         r_state     <= WR_IDLE;
         r_beat      <= '0;
         r_wrPtr     <= '0;
         r_shadowPtr <= '0;
         r_rdPtr     <= '0;
         r_level     <= '0;
      end else begin
         if (w_sofBeat) begin
            r_beat      <= BEAT_W'(1);
            r_shadowPtr <= w_spaceOk ? r_wrPtr + PTR_W'(1) : r_wrPtr;
            r_state     <= w_spaceOk ? WR_FILL : WR_DROP;
         end else if (w_dataBeat) begin
            case (r_state)
               WR_FILL: begin
                  r_shadowPtr <= r_shadowPtr + PTR_W'(1);
                  if (r_beat == C_LAST_BEAT) begin
                     r_wrPtr <= r_shadowPtr + PTR_W'(1);
                     r_beat  <= '0;
                     r_state <= WR_IDLE;
                  end else begin
                     r_beat <= r_beat + BEAT_W'(1);
                  end
               end
               WR_DROP: begin
                  if (r_beat == C_LAST_BEAT) begin
                     r_beat  <= '0;
                     r_state <= WR_IDLE;
                  end else begin
                     r_beat <= r_beat + BEAT_W'(1);
                  end
               end
               default: begin
                  r_state <= WR_IDLE;
               end
            endcase
         end
         if (w_popOk) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         r_level <= r_level + (w_commit ? C_FRAME : '0) - (w_popOk ? LEVEL_W'(1) : '0);
      end
   end

   // Sticky flags, saturating drop counter and interrupt; untouched by flush,
   // and a set event takes priority over a same-cycle clear
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_flags   <= '0;
         r_dropCnt <= '0;
         r_irq     <= 1'b0;
      end else begin
         if (w_setOvr) begin
            r_flags[FLAG_OVERRUN_BIT] <= 1'b1;
         end else if (clr_flags_i) begin
            r_flags[FLAG_OVERRUN_BIT] <= 1'b0;
         end
         if (w_setErr) begin
            r_flags[FLAG_FRAME_ERR_BIT] <= 1'b1;
         end else if (clr_flags_i) begin
            r_flags[FLAG_FRAME_ERR_BIT] <= 1'b0;
         end
         if (w_setOvr && (r_dropCnt != 16'hFFFF)) begin
            r_dropCnt <= r_dropCnt + 16'd1;
         end
         r_irq <= r_flags[FLAG_OVERRUN_BIT] | w_wmHit;
      end
   end

   assign rd_data_o    = (r_level == '0) ? '0 : w_ramData;
   assign level_o      = r_level;
   assign overrun_o    = r_flags[FLAG_OVERRUN_BIT];
   assign frame_err_o  = r_flags[FLAG_FRAME_ERR_BIT];
   assign drop_count_o = r_dropCnt;
   assign irq_o        = r_irq;

endmodule

// File: tb/tb_adc_frame_fifo.sv
// Testbench for adc_frame_fifo. Two instances (DEPTH=32 and DEPTH=16) share
// the same stimulus; a list-based frame model predicts both every cycle.
`timescale 1ns/1ps
module tb_adc_frame_fifo;

   localparam int FRAME_W = 9;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        flush    = 1'b0;
   logic        inValid  = 1'b0;
   logic        inSof    = 1'b0;
   logic [31:0] inData   = '0;
   logic        pop      = 1'b0;
   logic        clrFlags = 1'b0;
   int          wmSetting = 0;
   logic [5:0]  wm0;
   logic [4:0]  wm1;

   logic [31:0] rdData0, rdData1;
   logic [5:0]  level0;
   logic [4:0]  level1;
   logic        ovr0, ovr1, ferr0, ferr1, irq0, irq1;
   logic [15:0] drop0, drop1;

   int  testsRun  = 0;
   int  testsFail = 0;
   bit  checkEn   = 1'b0;
   bit  wmBuild   = 1'b0;

   int          mDepth [2] = '{32, 16};
   int          mCnt   [2];
   logic [31:0] mList  [2][64];
   logic [31:0] mStg   [2][16];
   int          mStgCnt[2];
   int          mMode  [2];
   int          mDropBeats[2];
   bit          mOvr[2], mErr[2], mIrq[2];
   int          mDrops[2];

   assign wm0 = wmSetting[5:0];
   assign wm1 = wmSetting[4:0];

   always #5 clk = ~clk;

   adc_frame_fifo #(.DATA_W(32), .DEPTH(32), .NUM_CH(8)) dut0 (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .flush_i(flush), .in_valid_i(inValid),
      .in_sof_i(inSof), .in_data_i(inData), .pop_i(pop), .rd_data_o(rdData0),
      .level_o(level0), .clr_flags_i(clrFlags), .overrun_o(ovr0), .frame_err_o(ferr0),
      .drop_count_o(drop0), .wm_i(wm0), .irq_o(irq0)
   );

   adc_frame_fifo #(.DATA_W(32), .DEPTH(16), .NUM_CH(8)) dut1 (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .flush_i(flush), .in_valid_i(inValid),
      .in_sof_i(inSof), .in_data_i(inData), .pop_i(pop), .rd_data_o(rdData1),
      .level_o(level1), .clr_flags_i(clrFlags), .overrun_o(ovr1), .frame_err_o(ferr1),
      .drop_count_o(drop1), .wm_i(wm1), .irq_o(irq1)
   );

   // One comparison: counts it and reports a FAIL line on disagreement
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the frame model of instance k by one clock using the current inputs
   task automatic modelStep(input int k);
      bit hit, newIrq, setOvr, setErr, popOk, commit;
      hit = 1'b0;
`ifdef HOME_INV_ADC_FIFO_WM_EN
      hit = (wmSetting != 0) && (mCnt[k] >= wmSetting);
`endif
      newIrq = mOvr[k] | hit;
      setOvr = 1'b0;
      setErr = 1'b0;
      commit = 1'b0;
      if (flush) begin
         mCnt[k]    = 0;
         mStgCnt[k] = 0;
         mMode[k]   = 0;
      end else begin
         popOk = pop && (mCnt[k] > 0);
         if (inValid && inSof) begin
            if (mMode[k] != 0) setErr = 1'b1;
            mStgCnt[k] = 0;
            if (mDepth[k] - mCnt[k] >= FRAME_W) begin
               mMode[k]    = 1;
               mStg[k][0]  = inData;
               mStgCnt[k]  = 1;
            end else begin
               mMode[k]      = 2;
               mDropBeats[k] = 1;
               setOvr        = 1'b1;
               if (mDrops[k] < 65535) mDrops[k]++;
            end
         end else if (inValid) begin
            if (mMode[k] == 0) begin
               setErr = 1'b1;
            end else if (mMode[k] == 1) begin
               mStg[k][mStgCnt[k]] = inData;
               mStgCnt[k]++;
               if (mStgCnt[k] == FRAME_W) commit = 1'b1;
            end else begin
               mDropBeats[k]++;
               if (mDropBeats[k] == FRAME_W) mMode[k] = 0;
            end
         end
         if (popOk) begin
            for (int i = 0; i < mCnt[k] - 1; i++) mList[k][i] = mList[k][i+1];
            mCnt[k]--;
         end
         if (commit) begin
            for (int i = 0; i < FRAME_W; i++) mList[k][mCnt[k]+i] = mStg[k][i];
            mCnt[k]    += FRAME_W;
            mStgCnt[k]  = 0;
            mMode[k]    = 0;
         end
      end
      if (setOvr) mOvr[k] = 1'b1;
      else if (clrFlags) mOvr[k] = 1'b0;
      if (setErr) mErr[k] = 1'b1;
      else if (clrFlags) mErr[k] = 1'b0;
      mIrq[k] = newIrq;
   endtask

   // Model update on each clock, cleared whenever reset is asserted
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            mCnt[k] = 0; mStgCnt[k] = 0; mMode[k] = 0; mDropBeats[k] = 0;
            mOvr[k] = 1'b0; mErr[k] = 1'b0; mIrq[k] = 1'b0; mDrops[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) modelStep(k);
      end
   end

   // Compare both instances against the model on every falling edge
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("level0", 32'(level0), mCnt[0]);
         checkOutput("rdData0", rdData0, (mCnt[0] > 0) ? mList[0][0] : 32'h0);
         checkOutput("overrun0", 32'(ovr0), 32'(mOvr[0]));
         checkOutput("frameErr0", 32'(ferr0), 32'(mErr[0]));
         checkOutput("drops0", 32'(drop0), mDrops[0]);
         checkOutput("irq0", 32'(irq0), 32'(mIrq[0]));
         checkOutput("level1", 32'(level1), mCnt[1]);
         checkOutput("rdData1", rdData1, (mCnt[1] > 0) ? mList[1][0] : 32'h0);
         checkOutput("overrun1", 32'(ovr1), 32'(mOvr[1]));
         checkOutput("frameErr1", 32'(ferr1), 32'(mErr[1]));
         checkOutput("drops1", 32'(drop1), mDrops[1]);
         checkOutput("irq1", 32'(irq1), 32'(mIrq[1]));
      end
   end

   // Drive one cycle of inputs, then return them to idle after the edge
   task automatic applyStimulus(input bit v, input bit s, input logic [31:0] d,
                                input bit p, input bit f, input bit c);
      @(negedge clk); #1;
      inValid = v; inSof = s; inData = d; pop = p; flush = f; clrFlags = c;
      @(posedge clk); #1;
      inValid = 1'b0; inSof = 1'b0; inData = '0; pop = 1'b0; flush = 1'b0; clrFlags = 1'b0;
   endtask

   // Send nWords of a frame: status word, then base+1, base+2, ...
   task automatic sendFrame(input logic [31:0] status, input logic [31:0] base,
                            input int nWords, input bit popLast);
      for (int i = 0; i < nWords; i++) begin
         applyStimulus(1'b1, i == 0, (i == 0) ? status : base + 32'(i),
                       popLast && (i == nWords - 1), 1'b0, 1'b0);
      end
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
`ifdef HOME_INV_ADC_FIFO_WM_EN
      wmBuild = 1'b1;
`endif
      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst level0", 32'(level0), 0);
      checkOutput("rst rdData0", rdData0, 0);
      checkOutput("rst overrun0", 32'(ovr0), 0);
      checkOutput("rst frameErr0", 32'(ferr0), 0);
      checkOutput("rst drops0", 32'(drop0), 0);
      checkOutput("rst irq0", 32'(irq0), 0);
      checkOutput("rst level1", 32'(level1), 0);
      #1 rst_n = 1'b1;
      checkEn = 1'b1;

      // Single frame, then read back in order
      sendFrame(32'h0, 32'h1000, 9, 1'b0);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i == 0) checkOutput("A level0", 32'(level0), 9);
         checkOutput("A word", rdData0, (i == 0) ? 32'h0 : 32'h1000 + 32'(i));
         applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
      @(negedge clk);
      checkOutput("A level0 empty", 32'(level0), 0);
      checkOutput("A rdData0 empty", rdData0, 0);

      // Second frame does not fit in the small instance
      sendFrame(32'h1, 32'h2000, 9, 1'b0);
      sendFrame(32'h2, 32'h3000, 9, 1'b0);
      @(negedge clk);
      checkOutput("B level1", 32'(level1), 9);
      checkOutput("B overrun1", 32'(ovr1), 1);
      checkOutput("B drops1", 32'(drop1), 1);
      checkOutput("B irq1", 32'(irq1), 1);
      checkOutput("B level0", 32'(level0), 18);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("B overrun1 clr", 32'(ovr1), 0);
      drain(18);

      // SOF after four words restarts the frame
      sendFrame(32'h3, 32'h4000, 4, 1'b0);
      sendFrame(32'h4, 32'h5000, 9, 1'b0);
      @(negedge clk);
      checkOutput("C frameErr0", 32'(ferr0), 1);
      checkOutput("C level0", 32'(level0), 9);
      checkOutput("C head0", rdData0, 32'h4);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      drain(9);

      // Pop coinciding with a commit
      sendFrame(32'h5, 32'h6000, 9, 1'b0);
      sendFrame(32'h6, 32'h7000, 9, 1'b1);
      @(negedge clk);
      checkOutput("D level0", 32'(level0), 17);
      checkOutput("D head0", rdData0, 32'h6001);
      checkOutput("D level1", 32'(level1), 8);
      checkOutput("D drops1", 32'(drop1), 2);
      drain(17);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Pointer wrap in the small instance
      for (int k = 0; k < 5; k++) begin
         sendFrame(32'h10 + 32'(k), 32'h8000 + 32'(k * 256), 9, 1'b0);
         @(negedge clk);
         checkOutput("E head1", rdData1, 32'h10 + 32'(k));
         drain(9);
      end

      // Flush mid-frame, with a valid word and pop in the flush cycle
      sendFrame(32'h20, 32'h9000, 4, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'hDEAD, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("E flush level1", 32'(level1), 0);
      sendFrame(32'h21, 32'hA000, 9, 1'b0);
      @(negedge clk);
      checkOutput("E after flush level1", 32'(level1), 9);
      checkOutput("E after flush head1", rdData1, 32'h21);
      checkOutput("E after flush frameErr1", 32'(ferr1), 0);
      drain(9);

      // Reset in the middle of a frame
      sendFrame(32'h30, 32'hB000, 5, 1'b0);
      @(negedge clk); #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("F rst drops1", 32'(drop1), 0);
      #1 rst_n = 1'b1;
      sendFrame(32'h31, 32'hC000, 9, 1'b0);
      @(negedge clk);
      checkOutput("F level0", 32'(level0), 9);
      checkOutput("F frameErr0", 32'(ferr0), 0);
      drain(9);

      // Watermark interrupt
      wmSetting = 9;
      sendFrame(32'h40, 32'hD000, 9, 1'b0);
      @(negedge clk);
      checkOutput("G level0", 32'(level0), 9);
      checkOutput("G irq0 early", 32'(irq0), 0);
      @(negedge clk);
      checkOutput("G irq0", 32'(irq0), wmBuild ? 1 : 0);
      drain(9);
      wmSetting = 0;

      repeat (3) @(negedge clk);
      checkEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule
